// File: rtl/vc_scheduler.sv
// vc_scheduler: moves words from two virtual-channel FIFOs (VC0, VC1) to two
// destination FIFOs (D0, D1). VC0 has strict priority, and a word only moves
// when its destination is not almost full. The block also owns the FIFO
// thresholds, which are loaded while the FSM sits in INIT.
module vc_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [1:0] umbral_mf_in,
    input  logic [1:0] umbral_d0_in,
    input  logic [1:0] umbral_d1_in,
    input  logic [3:0] umbral_vc0_in,
    input  logic [3:0] umbral_vc1_in,
    output logic [1:0] umbral_mf,
    output logic [1:0] umbral_d0,
    output logic [1:0] umbral_d1,
    output logic [3:0] umbral_vc0,
    output logic [3:0] umbral_vc1,
    input  logic       vc0_empty,
    input  logic       vc1_empty,
    input  logic [5:0] vc0_data,
    input  logic [5:0] vc1_data,
    input  logic       d0_almost_full,
    input  logic       d1_almost_full,
    input  logic [4:0] fifo_empty,
    input  logic [4:0] fifo_error,
    output logic       pop_vc0,
    output logic       pop_vc1,
    output logic       push_d0,
    output logic       push_d1,
    output logic [5:0] data_out,
    output logic       active_out,
    output logic       idle_out,
    output logic       error_out,
    output logic [4:0] state_out
);

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    logic [4:0] state_r;
    logic [4:0] next_state_s;
    logic       pop_vc0_s;
    logic       pop_vc1_s;
    logic       push_d0_r;
    logic       push_d1_r;
    logic [5:0] data_out_r;
    logic       active_r;
    logic       idle_r;
    logic       error_r;
    logic [1:0] umbral_mf_r;
    logic [1:0] umbral_d0_r;
    logic [1:0] umbral_d1_r;
    logic [3:0] umbral_vc0_r;
    logic [3:0] umbral_vc1_r;

    // Bit 4 of a head word selects its destination: 0 -> D0, 1 -> D1.
    function automatic logic dest_blocked(input logic [5:0] word,
                                          input logic       d0_af,
                                          input logic       d1_af);
        if (word[4]) begin
            dest_blocked = d1_af;
        end else begin
            dest_blocked = d0_af;
        end
    endfunction

    // Next-state logic; error outranks init, which outranks the traffic check.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RESET: begin
                next_state_s = ST_INIT;
            end
            ST_INIT: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (fifo_error != 5'b00000) begin
                    next_state_s = ST_ERROR;
                end else if (init) begin
                    next_state_s = ST_INIT;
                end else if (fifo_empty != 5'b11111) begin
                    next_state_s = ST_ACTIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ERROR: begin
                next_state_s = ST_ERROR;
            end
            default: begin
                next_state_s = ST_RESET;
            end
        endcase
    end

    // Pop arbitration: VC0 first; VC1 only when VC0 is not popping this cycle.
    always_comb begin
        pop_vc0_s = 1'b0;
        pop_vc1_s = 1'b0;
        if (state_r == ST_ACTIVE) begin
            if (!vc0_empty && !dest_blocked(vc0_data, d0_almost_full, d1_almost_full)) begin
                pop_vc0_s = 1'b1;
            end else if (!vc1_empty && !dest_blocked(vc1_data, d0_almost_full, d1_almost_full)) begin
                pop_vc1_s = 1'b1;
            end else begin
                pop_vc0_s = 1'b0;
                pop_vc1_s = 1'b0;
            end
        end else begin
            pop_vc0_s = 1'b0;
            pop_vc1_s = 1'b0;
        end
    end

    // State register and status flags, which track the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_RESET;
            active_r <= 1'b0;
            idle_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            active_r <= (next_state_s == ST_ACTIVE);
            idle_r   <= (next_state_s == ST_IDLE);
            error_r  <= (next_state_s == ST_ERROR);
        end
    end

    // Push stage: the popped word is written to its destination one cycle
    // later. This completes even if the state has moved on; only reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_d0_r  <= 1'b0;
            push_d1_r  <= 1'b0;
            data_out_r <= 6'd0;
        end else if (pop_vc0_s) begin
            push_d0_r  <= ~vc0_data[4];
            push_d1_r  <= vc0_data[4];
            data_out_r <= vc0_data;
        end else if (pop_vc1_s) begin
            push_d0_r  <= ~vc1_data[4];
            push_d1_r  <= vc1_data[4];
            data_out_r <= vc1_data;
        end else begin
            push_d0_r  <= 1'b0;
            push_d1_r  <= 1'b0;
            data_out_r <= data_out_r;
        end
    end

    // Thresholds follow the inputs only while in INIT and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            umbral_mf_r  <= 2'd3;
            umbral_d0_r  <= 2'd3;
            umbral_d1_r  <= 2'd3;
            umbral_vc0_r <= 4'd12;
            umbral_vc1_r <= 4'd12;
        end else if (state_r == ST_INIT) begin
            umbral_mf_r  <= umbral_mf_in;
            umbral_d0_r  <= umbral_d0_in;
            umbral_d1_r  <= umbral_d1_in;
            umbral_vc0_r <= umbral_vc0_in;
            umbral_vc1_r <= umbral_vc1_in;
        end else begin
            umbral_mf_r  <= umbral_mf_r;
            umbral_d0_r  <= umbral_d0_r;
            umbral_d1_r  <= umbral_d1_r;
            umbral_vc0_r <= umbral_vc0_r;
            umbral_vc1_r <= umbral_vc1_r;
        end
    end

    assign pop_vc0    = pop_vc0_s;
    assign pop_vc1    = pop_vc1_s;
    assign push_d0    = push_d0_r;
    assign push_d1    = push_d1_r;
    assign data_out   = data_out_r;
    assign active_out = active_r;
    assign idle_out   = idle_r;
    assign error_out  = error_r;
    assign state_out  = state_r;
    assign umbral_mf  = umbral_mf_r;
    assign umbral_d0  = umbral_d0_r;
    assign umbral_d1  = umbral_d1_r;
    assign umbral_vc0 = umbral_vc0_r;
    assign umbral_vc1 = umbral_vc1_r;

endmodule

// File: tb/tb_vc_scheduler.sv
// Testbench for vc_scheduler: directed bring-up, routing, priority, error and
// reset scenarios followed by randomized traffic, all compared against a
// behavioural model of the scheduler rules.
module tb_vc_scheduler;

    logic       clk;
    logic       reset;
    logic       init;
    logic [1:0] umbral_mf_in;
    logic [1:0] umbral_d0_in;
    logic [1:0] umbral_d1_in;
    logic [3:0] umbral_vc0_in;
    logic [3:0] umbral_vc1_in;
    logic [1:0] umbral_mf;
    logic [1:0] umbral_d0;
    logic [1:0] umbral_d1;
    logic [3:0] umbral_vc0;
    logic [3:0] umbral_vc1;
    logic       vc0_empty;
    logic       vc1_empty;
    logic [5:0] vc0_data;
    logic [5:0] vc1_data;
    logic       d0_almost_full;
    logic       d1_almost_full;
    logic [4:0] fifo_empty;
    logic [4:0] fifo_error;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       push_d0;
    logic       push_d1;
    logic [5:0] data_out;
    logic       active_out;
    logic       idle_out;
    logic       error_out;
    logic [4:0] state_out;

    vc_scheduler dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_mf_in(umbral_mf_in), .umbral_d0_in(umbral_d0_in),
        .umbral_d1_in(umbral_d1_in), .umbral_vc0_in(umbral_vc0_in),
        .umbral_vc1_in(umbral_vc1_in),
        .umbral_mf(umbral_mf), .umbral_d0(umbral_d0), .umbral_d1(umbral_d1),
        .umbral_vc0(umbral_vc0), .umbral_vc1(umbral_vc1),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1), .data_out(data_out),
        .active_out(active_out), .idle_out(idle_out), .error_out(error_out),
        .state_out(state_out)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model states are plain indices; the one-hot image is bit (index).
    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_state;
    logic       m_push_d0, m_push_d1;
    logic [5:0] m_data;
    logic [1:0] m_mf, m_d0, m_d1;
    logic [3:0] m_vc0, m_vc1;
    logic       exp_pop0, exp_pop1;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic blocked(input logic [5:0] w);
        return w[4] ? d1_almost_full : d0_almost_full;
    endfunction

    task automatic model_reset();
        m_state = M_RESET;
        m_push_d0 = 1'b0; m_push_d1 = 1'b0; m_data = 6'd0;
        m_mf = 2'd3; m_d0 = 2'd3; m_d1 = 2'd3; m_vc0 = 4'd12; m_vc1 = 4'd12;
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle_and_check();
        logic [4:0] one_hot;
        #1;
        one_hot = 5'd1;
        one_hot = one_hot << m_state;
        exp_pop0 = (m_state == M_ACTIVE) && !vc0_empty && !blocked(vc0_data);
        exp_pop1 = (m_state == M_ACTIVE) && !exp_pop0 && !vc1_empty && !blocked(vc1_data);
        check("state_out", 32'(state_out), 32'(one_hot));
        check("active_out", 32'(active_out), 32'(m_state == M_ACTIVE));
        check("idle_out", 32'(idle_out), 32'(m_state == M_IDLE));
        check("error_out", 32'(error_out), 32'(m_state == M_ERROR));
        check("pop_vc0", 32'(pop_vc0), 32'(exp_pop0));
        check("pop_vc1", 32'(pop_vc1), 32'(exp_pop1));
        check("push_d0", 32'(push_d0), 32'(m_push_d0));
        check("push_d1", 32'(push_d1), 32'(m_push_d1));
        check("data_out", 32'(data_out), 32'(m_data));
        check("umbral_mf", 32'(umbral_mf), 32'(m_mf));
        check("umbral_d0", 32'(umbral_d0), 32'(m_d0));
        check("umbral_d1", 32'(umbral_d1), 32'(m_d1));
        check("umbral_vc0", 32'(umbral_vc0), 32'(m_vc0));
        check("umbral_vc1", 32'(umbral_vc1), 32'(m_vc1));
    endtask

    // Apply the clock edge to the model, then move to the next falling edge.
    task automatic advance_cycle();
        if (reset) begin
            model_reset();
        end else begin
            m_push_d0 = 1'b0;
            m_push_d1 = 1'b0;
            if (exp_pop0) begin
                m_data = vc0_data; m_push_d1 = vc0_data[4]; m_push_d0 = !vc0_data[4];
            end else if (exp_pop1) begin
                m_data = vc1_data; m_push_d1 = vc1_data[4]; m_push_d0 = !vc1_data[4];
            end
            if (m_state == M_INIT) begin
                m_mf = umbral_mf_in; m_d0 = umbral_d0_in; m_d1 = umbral_d1_in;
                m_vc0 = umbral_vc0_in; m_vc1 = umbral_vc1_in;
            end
            case (m_state)
                M_RESET: m_state = M_INIT;
                M_INIT:  m_state = init ? M_INIT : M_IDLE;
                M_IDLE, M_ACTIVE: begin
                    if (fifo_error != 5'd0)       m_state = M_ERROR;
                    else if (init)                m_state = M_INIT;
                    else if (fifo_empty != 5'h1F) m_state = M_ACTIVE;
                    else                          m_state = M_IDLE;
                end
                default: m_state = M_ERROR;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle_and_check();
        advance_cycle();
    endtask

    task automatic quiet_inputs();
        reset = 1'b0; init = 1'b0;
        vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = 6'd0; vc1_data = 6'd0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        fifo_empty = 5'h1F; fifo_error = 5'd0;
    endtask

    initial begin
        quiet_inputs();
        umbral_mf_in = 2'd1; umbral_d0_in = 2'd2; umbral_d1_in = 2'd0;
        umbral_vc0_in = 4'd5; umbral_vc1_in = 4'd9;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Bring-up: RESET -> INIT (three init cycles) -> IDLE.
        reset = 1'b1; tick();
        check("bringup_reset_state", 32'(state_out), 32'h01);
        check("bringup_reset_vc0", 32'(umbral_vc0), 32'd12);
        reset = 1'b0; init = 1'b1;
        tick(); tick(); tick();
        init = 1'b0; tick();
        settle_and_check();
        check("bringup_idle_out", 32'(idle_out), 32'd1);
        check("bringup_vc0_thresh", 32'(umbral_vc0), 32'd5);
        advance_cycle();

        // Routing: VC0 head 6'b011011 goes to D1.
        fifo_empty = 5'b11110; vc0_empty = 1'b0; vc0_data = 6'b011011;
        tick();
        settle_and_check();
        check("route_pop_vc0", 32'(pop_vc0), 32'd1);
        advance_cycle();
        vc0_empty = 1'b1;
        settle_and_check();
        check("route_push_d1", 32'(push_d1), 32'd1);
        check("route_data", 32'(data_out), 32'h1B);
        advance_cycle();

        // Priority: VC0 to D0 blocked, VC1 head 6'b001101 also goes to D0.
        fifo_empty = 5'b11100; vc0_empty = 1'b0; vc0_data = 6'b000001;
        vc1_empty = 1'b0; vc1_data = 6'b001101; d0_almost_full = 1'b1;
        settle_and_check();
        check("prio_no_pop_vc0", 32'(pop_vc0), 32'd0);
        check("prio_no_pop_vc1", 32'(pop_vc1), 32'd0);
        advance_cycle();
        settle_and_check();
        check("prio_push_d0", 32'(push_d0), 32'd0);
        check("prio_push_d1", 32'(push_d1), 32'd0);
        advance_cycle();

        // Error while ACTIVE with init also raised: ERROR wins and sticks.
        d0_almost_full = 1'b0; fifo_error = 5'b00100; init = 1'b1;
        tick();
        fifo_error = 5'd0;
        repeat (4) begin
            settle_and_check();
            check("err_error_out", 32'(error_out), 32'd1);
            check("err_no_pop", 32'({pop_vc0, pop_vc1}), 32'd0);
            advance_cycle();
        end

        // Reset in the cycle of a pop drops the pending push.
        init = 1'b0; reset = 1'b1; tick();
        reset = 1'b0; tick(); tick(); tick();
        vc0_data = 6'b000111; reset = 1'b1;
        settle_and_check();
        check("rst_mid_pop_vc0", 32'(pop_vc0), 32'd1);
        advance_cycle();
        reset = 1'b0;
        settle_and_check();
        check("rst_mid_push", 32'({push_d0, push_d1}), 32'd0);
        check("rst_mid_state", 32'(state_out), 32'h01);
        advance_cycle();

        // Randomized traffic with occasional reset, init and errors.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            init  = ($urandom_range(0, 19) == 0);
            fifo_error = ($urandom_range(0, 79) == 0) ? 5'($urandom) : 5'd0;
            fifo_empty = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
            vc0_empty = 1'($urandom); vc1_empty = 1'($urandom);
            vc0_data = 6'($urandom); vc1_data = 6'($urandom);
            d0_almost_full = ($urandom_range(0, 2) == 0);
            d1_almost_full = ($urandom_range(0, 2) == 0);
            umbral_mf_in = 2'($urandom); umbral_d0_in = 2'($urandom);
            umbral_d1_in = 2'($urandom); umbral_vc0_in = 4'($urandom);
            umbral_vc1_in = 4'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
